dmem_arbiter: RTL and testbench



---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter_rr_pick2.sv | 24 ++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared state encoding and port indices for the DataMemory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational two-way round-robin chooser; `last` is the port
//            served most recently and loses a tie.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = req[1];
        if (&req) begin
            winner = ~last;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter sharing one DataMemory port between the CPU
//            (port 0) and the loader/debug engine (port 1). Optional access
//            statistics are enabled with the DMEM_ARB_STATS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1,
    output logic [31:0]       conflict_cnt,
`endif
    output logic              busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_valid;
    logic              w_winner;
    logic              w_capture;
    logic              w_rd_done0;
    logic              w_rd_done1;

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .last   (r_last),
        .valid  (w_valid),
        .winner (w_winner)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = (w_winner == PORT_LDR) ? GRANT1 : GRANT0;
                end
            end
            GRANT0, GRANT1: w_state_nxt = IDLE;
            default:        w_state_nxt = IDLE;
        endcase
    end

    // A read completes at the edge closing its GRANT cycle.
    assign w_rd_done0 = (r_state == GRANT0) && !r_we;
    assign w_rd_done1 = (r_state == GRANT1) && !r_we;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_last  <= w_winner;
                r_we    <= (w_winner == PORT_CPU) ? we0    : we1;
                r_addr  <= (w_winner == PORT_CPU) ? addr0  : addr1;
                r_wdata <= (w_winner == PORT_CPU) ? wdata0 : wdata1;
            end
            r_rvalid0 <= w_rd_done0;
            r_rvalid1 <= w_rd_done1;
            if (w_rd_done0) begin
                r_rdata0 <= mem_rdata;
            end
            if (w_rd_done1) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    // Address/data come straight from the capture registers so they hold while idle.
    assign gnt0      = (r_state == GRANT0);
    assign gnt1      = (r_state == GRANT1);
    assign busy      = (r_state != IDLE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_write = busy && r_we;
    assign mem_read  = busy && !r_we;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_gnt_cnt0;
    logic [31:0] r_gnt_cnt1;
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_gnt_cnt0     <= '0;
            r_gnt_cnt1     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (r_state == GRANT0) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 32'd1;
            end
            if (r_state == GRANT1) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 32'd1;
            end
            if ((r_state == IDLE) && req0 && req1) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign gnt_cnt0     = r_gnt_cnt0;
    assign gnt_cnt1     = r_gnt_cnt1;
    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter with a behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy;
    logic [63:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .CLK(CLK), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt),
`endif
        .busy(busy)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DataMemory stand-in: combinational read, write at the clock edge.
    logic [63:0] tb_mem [32];
    always_comb mem_rdata = tb_mem[mem_addr[7:3]];
    always @(posedge CLK) if (mem_write) tb_mem[mem_addr[7:3]] = mem_wdata;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic miss(input string nm, input int due);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got none expected event at cycle %0d (now %0d)", nm, due, cyc);
    endtask

    // ---------------- reference model + scoreboard queues ----------------
    typedef struct { int cyc; int port; bit we; logic [63:0] addr; logic [63:0] wdata; } gnt_t;
    typedef struct { int cyc; logic [63:0] d; } rd_t;
    gnt_t gq[$];
    rd_t  rq0[$], rq1[$];
    logic [63:0] ref_mem [32];
    bit   m_last = 1'b1;
    int   m_gcyc = -10;
    int   m_g0 = 0, m_g1 = 0, m_conf = 0;
    gnt_t m_g;
    rd_t  m_r;

    always @(negedge CLK) begin
        if (reset) begin
            m_last = 1'b1;
            m_gcyc = -10;
            m_g0 = 0; m_g1 = 0; m_conf = 0;
            while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
            while (rq0.size() > 0 && rq0[$].cyc > cyc) void'(rq0.pop_back());
            while (rq1.size() > 0 && rq1[$].cyc > cyc) void'(rq1.pop_back());
        end else if (m_gcyc != cyc && (req0 || req1)) begin
            if (req0 && req1) begin
                m_conf++;
                m_g.port = m_last ? 0 : 1;
            end else begin
                m_g.port = req1 ? 1 : 0;
            end
            m_last    = (m_g.port == 1);
            m_gcyc    = cyc + 1;
            m_g.cyc   = cyc + 1;
            m_g.we    = (m_g.port == 0) ? we0 : we1;
            m_g.addr  = (m_g.port == 0) ? addr0 : addr1;
            m_g.wdata = (m_g.port == 0) ? wdata0 : wdata1;
            gq.push_back(m_g);
            if (m_g.port == 0) m_g0++; else m_g1++;
            if (m_g.we) begin
                ref_mem[m_g.addr[7:3]] = m_g.wdata;
            end else begin
                m_r.cyc = cyc + 2;
                m_r.d   = ref_mem[m_g.addr[7:3]];
                if (m_g.port == 0) rq0.push_back(m_r); else rq1.push_back(m_r);
            end
        end
    end

    // ---------------- monitor ----------------
    gnt_t o_g;
    rd_t  o_r;
    always @(negedge CLK) begin
        while (gq.size() > 0 && gq[0].cyc < cyc) begin miss("grant_missing", gq[0].cyc); void'(gq.pop_front()); end
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            o_g = gq.pop_front();
            chk("busy_grant", {63'd0, busy}, 64'd1);
            chk("gnt0", {63'd0, gnt0}, {63'd0, o_g.port == 0});
            chk("gnt1", {63'd0, gnt1}, {63'd0, o_g.port == 1});
            chk("mem_addr", mem_addr, o_g.addr);
            chk("mem_write", {63'd0, mem_write}, {63'd0, o_g.we});
            chk("mem_read", {63'd0, mem_read}, {63'd0, !o_g.we});
            if (o_g.we) chk("mem_wdata", mem_wdata, o_g.wdata);
        end else begin
            chk("idle_strobes", {60'd0, busy, gnt0, gnt1, mem_read | mem_write}, 64'd0);
        end
        while (rq0.size() > 0 && rq0[0].cyc < cyc) begin miss("rvalid0_missing", rq0[0].cyc); void'(rq0.pop_front()); end
        if (rq0.size() > 0 && rq0[0].cyc == cyc) begin
            o_r = rq0.pop_front();
            chk("rvalid0", {63'd0, rvalid0}, 64'd1);
            chk("rdata0", rdata0, o_r.d);
        end else chk("rvalid0_idle", {63'd0, rvalid0}, 64'd0);
        while (rq1.size() > 0 && rq1[0].cyc < cyc) begin miss("rvalid1_missing", rq1[0].cyc); void'(rq1.pop_front()); end
        if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
            o_r = rq1.pop_front();
            chk("rvalid1", {63'd0, rvalid1}, 64'd1);
            chk("rdata1", rdata1, o_r.d);
        end else chk("rvalid1_idle", {63'd0, rvalid1}, 64'd0);
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Presents one access, holds it through its grant, then releases unless keep.
    task automatic do_access(input int p, input bit we, input logic [63:0] a,
                             input logic [63:0] d, input bit keep);
        int t;
        if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        t = 0;
        do begin
            @(negedge CLK);
            t++;
        end while (!((p == 0) ? gnt0 : gnt1) && t < 50);
        if (t >= 50) miss("grant_timeout", cyc);
        @(posedge CLK); #1;
        if (!keep) begin
            if (p == 0) req0 = 0; else req1 = 0;
        end
    endtask

    task automatic rand_driver(input int p);
        int gap;
        repeat (40) begin
            gap = $urandom_range(0, 3);
            do_access(p, 1'($urandom_range(0, 1)), {56'd0, 5'($urandom_range(0, 31)), 3'b000},
                      {$urandom, $urandom}, 1'b0);
            idle(gap);
        end
    endtask

    task automatic check_stats();
`ifdef DMEM_ARB_STATS_EN
        chk("gnt_cnt0", {32'd0, gnt_cnt0}, {32'd0, 32'(m_g0)});
        chk("gnt_cnt1", {32'd0, gnt_cnt1}, {32'd0, 32'(m_g1)});
        chk("conflict_cnt", {32'd0, conflict_cnt}, {32'd0, 32'(m_conf)});
`endif
    endtask

    initial begin
        logic [63:0] v;
        for (int i = 0; i < 32; i++) begin
            v = {$urandom, $urandom};
            tb_mem[i] = v;
            ref_mem[i] = v;
        end
        tb_mem[2]  = 64'hDEAD_BEEF;
        ref_mem[2] = 64'hDEAD_BEEF;

        idle(3);
        chk("reset_state", {57'd0, gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, busy}, 64'd0);
        chk("reset_rdata0", rdata0, 64'd0);
        chk("reset_rdata1", rdata1, 64'd0);
        chk("reset_mem_addr", mem_addr, 64'd0);
        chk("reset_mem_wdata", mem_wdata, 64'd0);
        reset = 0;

        do_access(0, 1'b0, 64'h10, 64'd0, 1'b0);
        idle(3);
        chk("single_read_rdata0", rdata0, 64'hDEAD_BEEF);

        do_access(1, 1'b1, 64'h20, 64'h1234, 1'b0);
        do_access(0, 1'b0, 64'h20, 64'd0, 1'b0);
        idle(3);
        chk("wr_then_rd_rdata0", rdata0, 64'h1234);

        do_access(0, 1'b0, 64'h00, 64'd0, 1'b1);
        do_access(0, 1'b0, 64'h08, 64'd0, 1'b1);
        do_access(0, 1'b0, 64'h10, 64'd0, 1'b0);
        idle(3);

        // Reset lands in the GRANT0 cycle of a read.
        req0 = 1; we0 = 0; addr0 = 64'h18;
        idle(1);
        chk("midreset_in_grant0", {63'd0, gnt0}, 64'd1);
        reset = 1; req0 = 0;
        idle(1);
        chk("midreset_rvalid0", {63'd0, rvalid0}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_mem_read", {63'd0, mem_read}, 64'd0);
        chk("midreset_rdata0", rdata0, 64'd0);
        reset = 0;

        fork
            begin
                do_access(0, 1'b0, 64'h10, 64'd0, 1'b1);
                do_access(0, 1'b1, 64'h28, 64'hA5A5_0001, 1'b0);
            end
            begin
                do_access(1, 1'b0, 64'h08, 64'd0, 1'b1);
                do_access(1, 1'b1, 64'h30, 64'h5A5A_0002, 1'b0);
            end
        join
        idle(4);
        check_stats();

        fork
            rand_driver(0);
            rand_driver(1);
        join
        idle(6);
        chk("grant_queue_drained", 64'(gq.size()), 64'd0);
        chk("read0_queue_drained", 64'(rq0.size()), 64'd0);
        chk("read1_queue_drained", 64'(rq1.size()), 64'd0);
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
